// File: rtl/sd_crypt_pkg.sv
// Shared definitions for the SD XOR block engine: default widths, timeout and FSM state encodings.
package sd_crypt_pkg;

   localparam int DEF_DATA_WIDTH = 512;
   localparam int DEF_KEY_WIDTH  = 128;
   localparam int DEF_NUM_KEYS   = 4;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_CNT_WIDTH  = 8;
   localparam int DEF_TIMEOUT    = 65535;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_RD_REQ  = 4'd1,
      ST_RD_WAIT = 4'd2,
      ST_XOR     = 4'd3,
      ST_WR_REQ  = 4'd4,
      ST_WR_WAIT = 4'd5,
      ST_NEXT    = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERR     = 4'd8
   } state_t;

   // States in which the engine is waiting on the SD controller and may time out.
   function automatic logic is_timed(input state_t s);
      return (s == ST_RD_REQ) || (s == ST_RD_WAIT) || (s == ST_WR_REQ) || (s == ST_WR_WAIT);
   endfunction

endpackage

// File: rtl/sd_key_bank.sv
// Key slot storage: NUM_KEYS registers of KEY_WIDTH bits, one write port, asynchronous read port.
module sd_key_bank
   import sd_crypt_pkg::*;
#(
   parameter int KEY_WIDTH = DEF_KEY_WIDTH,
   parameter int NUM_KEYS  = DEF_NUM_KEYS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [$clog2(NUM_KEYS)-1:0] waddr,
   input  logic [KEY_WIDTH-1:0]        wdata,
   input  logic [$clog2(NUM_KEYS)-1:0] raddr,
   output logic [KEY_WIDTH-1:0]        rdata
);

   logic [KEY_WIDTH-1:0] slots [NUM_KEYS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_KEYS; i++) slots[i] <= '0;
      end else if (we) begin
         slots[waddr] <= wdata;
      end
   end

   assign rdata = slots[raddr];

endmodule

// File: rtl/sd_xor_block_engine.sv
// Multi-block in-place XOR cipher engine between the key bank and the SD controller.
// Optional build macro KEY_ROTATE_EN: rotate the working key left by one bit after each block.
module sd_xor_block_engine
   import sd_crypt_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
   parameter int NUM_KEYS   = DEF_NUM_KEYS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [ADDR_WIDTH-1:0]       base_addr,
   input  logic [CNT_WIDTH-1:0]        blk_count,
   input  logic [$clog2(NUM_KEYS)-1:0] key_sel,
   input  logic                        key_we,
   input  logic [$clog2(NUM_KEYS)-1:0] key_waddr,
   input  logic [KEY_WIDTH-1:0]        key_wdata,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [CNT_WIDTH-1:0]        blocks_done,
   input  logic                        sd_ready,
   output logic                        sd_rd_req,
   output logic                        sd_wr_req,
   output logic [ADDR_WIDTH-1:0]       sd_addr,
   input  logic                        sd_rd_valid,
   input  logic [DATA_WIDTH-1:0]       sd_rd_data,
   output logic [DATA_WIDTH-1:0]       sd_wr_data,
   input  logic                        sd_wr_done
);

   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int REPS = DATA_WIDTH / KEY_WIDTH;

   state_t                state, next_state;
   logic [TW-1:0]         tcnt;
   logic                  timed_out;
   logic [CNT_WIDTH:0]    remaining;
   logic [ADDR_WIDTH-1:0] addr;
   logic [KEY_WIDTH-1:0]  key_rdata;
   logic [KEY_WIDTH-1:0]  work_key;
   logic [DATA_WIDTH-1:0] rd_buf;

   sd_key_bank #(
      .KEY_WIDTH (KEY_WIDTH),
      .NUM_KEYS  (NUM_KEYS)
   ) u_key_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (key_we),
      .waddr (key_waddr),
      .wdata (key_wdata),
      .raddr (key_sel),
      .rdata (key_rdata)
   );

   // A timed state may be occupied for at most TIMEOUT cycles before ERR is entered.
   assign timed_out = (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (start) next_state = ST_RD_REQ;
         ST_RD_REQ:  if (sd_ready) next_state = ST_RD_WAIT;
                     else if (timed_out) next_state = ST_ERR;
         ST_RD_WAIT: if (sd_rd_valid) next_state = ST_XOR;
                     else if (timed_out) next_state = ST_ERR;
         ST_XOR:     next_state = ST_WR_REQ;
         ST_WR_REQ:  if (sd_ready) next_state = ST_WR_WAIT;
                     else if (timed_out) next_state = ST_ERR;
         ST_WR_WAIT: if (sd_wr_done) next_state = ST_NEXT;
                     else if (timed_out) next_state = ST_ERR;
         ST_NEXT:    next_state = (remaining != {{CNT_WIDTH{1'b0}}, 1'b1}) ? ST_RD_REQ : ST_DONE;
         ST_DONE:    next_state = ST_IDLE;
         ST_ERR:     next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      error = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_DONE: done  = 1'b1;
         ST_ERR:  error = 1'b1;
         default: busy  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        tcnt <= '0;
      else if (next_state != state || !is_timed(state)) tcnt <= '0;
      else                                            tcnt <= tcnt + 1'b1;
   end

   // Requests are registered pulses issued on the transition into the matching wait state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sd_rd_req   <= 1'b0;
         sd_wr_req   <= 1'b0;
         addr        <= '0;
         remaining   <= '0;
         blocks_done <= '0;
         work_key    <= '0;
         rd_buf      <= '0;
         sd_wr_data  <= '0;
      end else begin
         sd_rd_req <= (state == ST_RD_REQ) && sd_ready;
         sd_wr_req <= (state == ST_WR_REQ) && sd_ready;
         case (state)
            ST_IDLE: if (start) begin
               addr        <= base_addr;
               remaining   <= (blk_count == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, blk_count};
               blocks_done <= '0;
               work_key    <= key_rdata;
            end
            ST_RD_WAIT: if (sd_rd_valid) rd_buf <= sd_rd_data;
            ST_XOR:     sd_wr_data <= rd_buf ^ {REPS{work_key}};
            ST_NEXT: begin
               addr        <= addr + 1'b1;
               blocks_done <= blocks_done + 1'b1;
               remaining   <= remaining - 1'b1;
`ifdef KEY_ROTATE_EN
               work_key    <= {work_key[KEY_WIDTH-2:0], work_key[KEY_WIDTH-1]};
`else
               work_key    <= work_key;
`endif
            end
            default: ;
         endcase
      end
   end

   assign sd_addr = addr;

endmodule

// File: tb/tb_sd_xor_block_engine.sv
// Directed self-checking bench for sd_xor_block_engine with a small reactive SD controller model.
module tb_sd_xor_block_engine;

   logic         clk, rst, start;
   logic [31:0]  base_addr;
   logic [7:0]   blk_count;
   logic [1:0]   key_sel, key_waddr;
   logic         key_we;
   logic [127:0] key_wdata;
   logic         busy, done, error;
   logic [7:0]   blocks_done;
   logic         sd_ready, sd_rd_req, sd_wr_req, sd_rd_valid, sd_wr_done;
   logic [31:0]  sd_addr;
   logic [511:0] sd_rd_data, sd_wr_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [511:0] data;
   } txn_t;

   txn_t         log_q[$];
   logic [511:0] mem [logic [31:0]];
   bit           rd_resp_en = 1'b1;

   sd_xor_block_engine #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .blk_count(blk_count),
      .key_sel(key_sel), .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
      .busy(busy), .done(done), .error(error), .blocks_done(blocks_done),
      .sd_ready(sd_ready), .sd_rd_req(sd_rd_req), .sd_wr_req(sd_wr_req), .sd_addr(sd_addr),
      .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data), .sd_wr_data(sd_wr_data),
      .sd_wr_done(sd_wr_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SD controller model: answers each request one cycle after seeing it and logs traffic.
   initial begin : sd_model
      bit          rd_pend, wr_pend;
      logic [31:0] pa;
      txn_t        t;
      sd_rd_valid = 1'b0; sd_wr_done = 1'b0; sd_rd_data = '0;
      rd_pend = 1'b0; wr_pend = 1'b0; pa = '0;
      forever begin
         @(posedge clk); #1;
         sd_rd_valid = 1'b0;
         sd_wr_done  = 1'b0;
         if (rst) begin
            rd_pend = 1'b0;
            wr_pend = 1'b0;
         end else begin
            if (rd_pend) begin
               sd_rd_valid = 1'b1;
               sd_rd_data  = mem.exists(pa) ? mem[pa] : '0;
               rd_pend     = 1'b0;
            end
            if (wr_pend) begin
               sd_wr_done = 1'b1;
               wr_pend    = 1'b0;
            end
            if (sd_rd_req) begin
               t.wr = 1'b0; t.addr = sd_addr; t.data = '0;
               log_q.push_back(t);
               pa = sd_addr;
               rd_pend = rd_resp_en;
            end
            if (sd_wr_req) begin
               t.wr = 1'b1; t.addr = sd_addr; t.data = sd_wr_data;
               log_q.push_back(t);
               mem[sd_addr] = sd_wr_data;
               wr_pend = 1'b1;
            end
         end
      end
   end

   function automatic logic [511:0] rep(input logic [127:0] k);
      return {4{k}};
   endfunction

   // Key used for block i of a job that started with key k.
   function automatic logic [127:0] blk_key(input logic [127:0] k, input int i);
      logic [127:0] r;
      r = k;
`ifdef KEY_ROTATE_EN
      for (int n = 0; n < i; n++) r = {r[126:0], r[127]};
`endif
      return r;
   endfunction

   task automatic write_key(input logic [1:0] slot, input logic [127:0] val);
      @(negedge clk);
      key_we = 1'b1; key_waddr = slot; key_wdata = val;
      @(negedge clk);
      key_we = 1'b0;
   endtask

   task automatic run_job(input logic [31:0] addr, input logic [7:0] cnt, input logic [1:0] sel,
                          input int max_cycles, input int poke_start_at, input int poke_key_at,
                          input logic [127:0] poke_key_val,
                          output int n_done, output int n_err, output bit finished, output bit busy_seen);
      log_q.delete();
      @(negedge clk);
      base_addr = addr; blk_count = cnt; key_sel = sel; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_seen = busy;
      n_done = 0; n_err = 0; finished = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (i == poke_start_at) begin start = 1'b1; base_addr = 32'h999; end
         else start = 1'b0;
         if (i == poke_key_at) begin key_we = 1'b1; key_waddr = 2'd0; key_wdata = poke_key_val; end
         else key_we = 1'b0;
         if (done)  n_done++;
         if (error) n_err++;
         if (!busy) begin finished = 1'b1; break; end
         @(negedge clk);
      end
      start = 1'b0; key_we = 1'b0;
      @(negedge clk);
      if (done)  n_done++;
      if (error) n_err++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, error, sd_rd_req, sd_wr_req} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, error, sd_rd_req, sd_wr_req});
      end
      checks++;
      if ({sd_addr, blocks_done} !== 40'h0) begin
         errors++; $display("[TB] FAIL reset_addr_cnt: got %h expected 0", {sd_addr, blocks_done});
      end
      checks++;
      if (sd_wr_data !== 512'h0) begin
         errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", sd_wr_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_block();
      int nd, ne; bit fin, bs;
      write_key(2'd0, {16{8'hA5}});
      mem.delete();
      run_job(32'h10, 8'd1, 2'd0, 100, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (!fin || !bs) begin errors++; $display("[TB] FAIL single_busy: finished %0d busy_after_start %0d expected 1 1", fin, bs); end
      checks++;
      if (nd != 1 || ne != 0) begin errors++; $display("[TB] FAIL single_pulses: done %0d error %0d expected 1 0", nd, ne); end
      checks++;
      if (log_q.size() != 2) begin
         errors++; $display("[TB] FAIL single_txn_count: got %0d expected 2", log_q.size());
      end else begin
         checks++;
         if (log_q[0].wr || log_q[0].addr !== 32'h10) begin
            errors++; $display("[TB] FAIL single_read: got wr %0d addr %h expected 0 00000010", log_q[0].wr, log_q[0].addr);
         end
         checks++;
         if (!log_q[1].wr || log_q[1].addr !== 32'h10 || log_q[1].data !== {64{8'hA5}}) begin
            errors++; $display("[TB] FAIL single_write: got addr %h data %h expected 00000010 all A5", log_q[1].addr, log_q[1].data);
         end
      end
      checks++;
      if (blocks_done !== 8'd1) begin errors++; $display("[TB] FAIL single_blocks_done: got %0d expected 1", blocks_done); end
   endtask

   task automatic test_multi_block();
      int nd, ne; bit fin, bs;
      logic [127:0] k;
      logic [31:0]  a [3];
      logic [511:0] d [3];
      k = 128'h0123456789ABCDEF_FEDCBA9876543210;
      a[0] = 32'hFFFFFFFE; a[1] = 32'hFFFFFFFF; a[2] = 32'h00000000;
      d[0] = {16{32'h11112222}}; d[1] = {16{32'h33334444}}; d[2] = {16{32'h55556666}};
      write_key(2'd1, k);
      mem.delete();
      for (int i = 0; i < 3; i++) mem[a[i]] = d[i];
      run_job(32'hFFFFFFFE, 8'd3, 2'd1, 200, 5, -1, '0, nd, ne, fin, bs);
      checks++;
      if (!fin || nd != 1 || ne != 0) begin
         errors++; $display("[TB] FAIL multi_end: finished %0d done %0d error %0d expected 1 1 0", fin, nd, ne);
      end
      checks++;
      if (log_q.size() != 6) begin
         errors++; $display("[TB] FAIL multi_txn_count: got %0d expected 6", log_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_q[2*i].wr || log_q[2*i].addr !== a[i]) begin
               errors++; $display("[TB] FAIL multi_read%0d: got wr %0d addr %h expected 0 %h", i, log_q[2*i].wr, log_q[2*i].addr, a[i]);
            end
            checks++;
            if (!log_q[2*i+1].wr || log_q[2*i+1].addr !== a[i] || log_q[2*i+1].data !== (d[i] ^ rep(blk_key(k, i)))) begin
               errors++; $display("[TB] FAIL multi_write%0d: got addr %h data %h expected %h %h", i, log_q[2*i+1].addr,
                                  log_q[2*i+1].data, a[i], d[i] ^ rep(blk_key(k, i)));
            end
         end
      end
      checks++;
      if (blocks_done !== 8'd3) begin errors++; $display("[TB] FAIL multi_blocks_done: got %0d expected 3", blocks_done); end
   endtask

   task automatic test_timeout();
      int req_at, err_at, n_err, n_wr;
      rd_resp_en = 1'b0;
      log_q.delete();
      req_at = -1; err_at = -1; n_err = 0; n_wr = 0;
      @(negedge clk);
      base_addr = 32'h200; blk_count = 8'd1; key_sel = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (sd_rd_req && req_at < 0) req_at = i;
         if (sd_wr_req) n_wr++;
         if (error) begin n_err++; if (err_at < 0) err_at = i; end
         @(negedge clk);
      end
      checks++;
      if (req_at < 0 || err_at < 0 || (err_at - req_at) != 16) begin
         errors++; $display("[TB] FAIL timeout_latency: req at %0d error at %0d expected distance 16", req_at, err_at);
      end
      checks++;
      if (n_err != 1 || n_wr != 0) begin
         errors++; $display("[TB] FAIL timeout_pulses: error %0d writes %0d expected 1 0", n_err, n_wr);
      end
      checks++;
      if (blocks_done !== 8'd0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL timeout_state: blocks_done %0d busy %b expected 0 0", blocks_done, busy);
      end
      rd_resp_en = 1'b1;
   endtask

   task automatic test_key_write_mid_job();
      int nd, ne; bit fin, bs;
      logic [127:0] k_old, k_new;
      logic [511:0] d0, d1;
      k_old = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
      k_new = {16{8'h55}};
      d0 = {8{64'h0F0F_0F0F_F0F0_F0F0}};
      d1 = {8{64'h1234_5678_9ABC_DEF0}};
      write_key(2'd0, k_old);
      mem.delete();
      mem[32'h300] = d0; mem[32'h301] = d1;
      run_job(32'h300, 8'd2, 2'd0, 200, -1, 2, k_new, nd, ne, fin, bs);
      checks++;
      if (log_q.size() != 4 || !fin) begin
         errors++; $display("[TB] FAIL keymid_txn_count: got %0d expected 4", log_q.size());
      end else begin
         checks++;
         if (log_q[1].data !== (d0 ^ rep(blk_key(k_old, 0)))) begin
            errors++; $display("[TB] FAIL keymid_blk0: got %h expected %h", log_q[1].data, d0 ^ rep(blk_key(k_old, 0)));
         end
         checks++;
         if (log_q[3].data !== (d1 ^ rep(blk_key(k_old, 1)))) begin
            errors++; $display("[TB] FAIL keymid_blk1: got %h expected %h", log_q[3].data, d1 ^ rep(blk_key(k_old, 1)));
         end
      end
      // The slot itself must now hold the new key.
      run_job(32'h310, 8'd1, 2'd0, 100, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (log_q.size() != 2 || log_q[1].data !== rep(k_new)) begin
         errors++; $display("[TB] FAIL keymid_new_slot: got %0d txns, last data %h expected %h", log_q.size(),
                            (log_q.size() > 0) ? log_q[log_q.size()-1].data : 512'h0, rep(k_new));
      end
   endtask

   task automatic test_reset_mid_job();
      int nd, ne, seen, n_log; bit fin, bs;
      logic [511:0] d;
      d = {16{32'hA1B2C3D4}};
      write_key(2'd0, {8{16'hBEEF}});
      mem.delete();
      mem[32'h400] = d; mem[32'h500] = d;
      log_q.delete();
      @(negedge clk);
      base_addr = 32'h400; blk_count = 8'd1; key_sel = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         if (sd_wr_req) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (seen == 0) begin errors++; $display("[TB] FAIL rstmid_reach_wr_wait: got 0 expected 1"); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, error, sd_rd_req, sd_wr_req} !== 5'b0 || {sd_addr, blocks_done} !== 40'h0 || sd_wr_data !== 512'h0) begin
         errors++; $display("[TB] FAIL rstmid_outputs: flags %b addr %h cnt %0d expected all zero",
                            {busy, done, error, sd_rd_req, sd_wr_req}, sd_addr, blocks_done);
      end
      n_log = log_q.size();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (log_q.size() != n_log || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_quiet: txns %0d busy %b expected %0d 0", log_q.size(), busy, n_log);
      end
      // Key slots were cleared by reset, so this job writes the data back unchanged.
      run_job(32'h500, 8'd1, 2'd0, 100, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (!fin || nd != 1 || log_q.size() != 2 || log_q[1].addr !== 32'h500 || log_q[1].data !== d) begin
         errors++; $display("[TB] FAIL rstmid_rerun: done %0d txns %0d data %h expected 1 2 %h", nd, log_q.size(),
                            (log_q.size() > 1) ? log_q[1].data : 512'h0, d);
      end
   endtask

   task automatic test_key_rotate();
      int nd, ne; bit fin, bs;
      write_key(2'd2, 128'h1);
      mem.delete();
      run_job(32'h600, 8'd2, 2'd2, 200, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (log_q.size() != 4) begin
         errors++; $display("[TB] FAIL rotate_txn_count: got %0d expected 4", log_q.size());
      end else begin
         checks++;
         if (log_q[1].data !== rep(blk_key(128'h1, 0))) begin
            errors++; $display("[TB] FAIL rotate_blk0: got %h expected %h", log_q[1].data, rep(blk_key(128'h1, 0)));
         end
         checks++;
         if (log_q[3].data !== rep(blk_key(128'h1, 1))) begin
            errors++; $display("[TB] FAIL rotate_blk1: got %h expected %h", log_q[3].data, rep(blk_key(128'h1, 1)));
         end
      end
      run_job(32'h600, 8'd2, 2'd2, 200, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (log_q.size() != 4 || log_q[1].data !== 512'h0 || log_q[3].data !== 512'h0) begin
         errors++; $display("[TB] FAIL rotate_restore: got %0d txns expected 4 with zero data", log_q.size());
      end
   endtask

   task automatic test_count_zero();
      int nd, ne; bit fin, bs;
      write_key(2'd3, 128'h77);
      mem.delete();
      run_job(32'h1000, 8'd0, 2'd3, 4000, -1, -1, '0, nd, ne, fin, bs);
      checks++;
      if (!fin || nd != 1 || log_q.size() != 512) begin
         errors++; $display("[TB] FAIL count_zero_len: finished %0d done %0d txns %0d expected 1 1 512", fin, nd, log_q.size());
      end else begin
         checks++;
         if (log_q[510].addr !== 32'h10FF || !log_q[511].wr || log_q[511].addr !== 32'h10FF) begin
            errors++; $display("[TB] FAIL count_zero_last_addr: got %h expected 000010ff", log_q[511].addr);
         end
      end
      checks++;
      if (blocks_done !== 8'd0) begin errors++; $display("[TB] FAIL count_zero_blocks_done: got %0d expected 0", blocks_done); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; blk_count = '0; key_sel = '0;
      key_we = 1'b0; key_waddr = '0; key_wdata = '0; sd_ready = 1'b1;
      test_reset();
      test_single_block();
      test_multi_block();
      test_timeout();
      test_key_write_mid_job();
      test_reset_mid_job();
      test_key_rotate();
      test_count_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
